// File: rtl/imm_decode_stage.sv
// Immediate decode stage: extracts the RISC-V immediate and format from an
// instruction word and buffers the result in a 2-entry FIFO with sideband tag.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_U     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_SHAMT = 3'd5;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_shift;
  logic signed [31:0] raw;
  logic [31:0]       shamt_val;
  logic [2:0]        dec_fmt;
  logic              dec_illegal;
  entry_t            dec_entry;

  entry_t            mem_q [2];
  entry_t            mem_d [2];
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              ready_en_q, ready_en_d;
  logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;
  logic              push, pop;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // RV64 OP-IMM shifts use a 6-bit shamt; RV32 and the W-form use 5 bits.
  assign shamt_val = (IS64 && (opcode == OP_IMM)) ? {26'b0, in_inst[25:20]}
                                                  : {27'b0, in_inst[24:20]};

  always_comb begin
    raw         = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec_fmt = FMT_I;
        raw     = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_IMM: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          raw     = shamt_val;
        end else begin
          dec_fmt = FMT_I;
          raw     = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
      OP_IMM32: begin
        if (!IS64) begin
          dec_illegal = 1'b1;
        end else if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          raw     = shamt_val;
        end else begin
          dec_fmt = FMT_I;
          raw     = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        raw     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        raw     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        raw     = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        raw     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      OP_OP, OP_MISC_MEM: begin
        dec_fmt = FMT_NONE;
      end
      OP_OP32: begin
        dec_illegal = !IS64;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_entry.imm     = XLEN'(raw);
  assign dec_entry.fmt     = dec_fmt;
  assign dec_entry.illegal = dec_illegal;
  assign dec_entry.tag     = in_tag;

  // ready_en_q holds in_ready low until the first edge after reset release.
  assign in_ready  = ready_en_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    mem_d         = mem_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ready_en_d    = 1'b1;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
    if (push && dec_illegal && !(&illegal_cnt_q)) begin
      illegal_cnt_d = illegal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      ready_en_q    <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      mem_q         <= mem_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ready_en_q    <= ready_en_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign out_imm     = mem_q[rd_ptr_q].imm;
  assign out_fmt     = mem_q[rd_ptr_q].fmt;
  assign out_illegal = mem_q[rd_ptr_q].illegal;
  assign out_tag     = mem_q[rd_ptr_q].tag;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: three parameterisations share one
// stimulus stream and are compared against a queue-based reference model.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        o32_in_ready, o32_out_valid, o32_out_illegal;
  logic [31:0] o32_out_imm;
  logic [2:0]  o32_out_fmt;
  logic [7:0]  o32_out_tag;
  logic [15:0] o32_cnt;

  logic        o64_in_ready, o64_out_valid, o64_out_illegal;
  logic [63:0] o64_out_imm;
  logic [2:0]  o64_out_fmt;
  logic [7:0]  o64_out_tag;
  logic [15:0] o64_cnt;

  logic        oc2_in_ready, oc2_out_valid, oc2_out_illegal;
  logic [31:0] oc2_out_imm;
  logic [2:0]  oc2_out_fmt;
  logic [7:0]  oc2_out_tag;
  logic [1:0]  oc2_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] q_inst[$];
  logic [7:0]  q_tag[$];
  int          m_cnt32, m_cnt64, m_cntc2;
  bit          m_init_done;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(o32_in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(o32_out_valid), .out_ready(out_ready), .out_imm(o32_out_imm),
    .out_fmt(o32_out_fmt), .out_illegal(o32_out_illegal), .out_tag(o32_out_tag),
    .illegal_cnt(o32_cnt));

  imm_decode_stage #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(o64_in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(o64_out_valid), .out_ready(out_ready), .out_imm(o64_out_imm),
    .out_fmt(o64_out_fmt), .out_illegal(o64_out_illegal), .out_tag(o64_out_tag),
    .illegal_cnt(o64_cnt));

  imm_decode_stage #(.XLEN(32), .TAG_W(8), .CNT_W(2)) dutc2 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(oc2_in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(oc2_out_valid), .out_ready(out_ready), .out_imm(oc2_out_imm),
    .out_fmt(oc2_out_fmt), .out_illegal(oc2_out_illegal), .out_tag(oc2_out_tag),
    .illegal_cnt(oc2_cnt));

  // Reference decode: fields are read as signed integers and scaled, then
  // truncated to the machine width.
  function automatic void refDecode(input logic [31:0] i, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output bit ill);
    longint v;
    bit     shift;
    v     = 0;
    ill   = 0;
    fmt   = 3'd7;
    shift = (i[14:12] == 3'b001) || (i[14:12] == 3'b101);
    case (i[6:0])
      7'h03, 7'h67, 7'h73: begin fmt = 3'd0; v = longint'($signed(i[31:20])); end
      7'h13: begin
        if (shift) begin
          fmt = 3'd5;
          v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
        end else begin
          fmt = 3'd0; v = longint'($signed(i[31:20]));
        end
      end
      7'h1B: begin
        if (xlen != 64) ill = 1;
        else if (shift) begin fmt = 3'd5; v = longint'(i[24:20]); end
        else begin fmt = 3'd0; v = longint'($signed(i[31:20])); end
      end
      7'h23: begin fmt = 3'd1; v = longint'($signed({i[31:25], i[11:7]})); end
      7'h63: begin fmt = 3'd2; v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2; end
      7'h37, 7'h17: begin fmt = 3'd3; v = longint'($signed(i[31:12])) * 4096; end
      7'h6F: begin fmt = 3'd4; v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2; end
      7'h33, 7'h0F: fmt = 3'd7;
      7'h3B: ill = (xlen != 64);
      default: ill = 1;
    endcase
    if (ill) begin fmt = 3'd7; v = 0; end
    imm = (xlen == 64) ? 64'(v) : {32'b0, v[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    q_inst.delete();
    q_tag.delete();
    m_cnt32 = 0; m_cnt64 = 0; m_cntc2 = 0;
    m_init_done = 0;
  endtask

  task automatic modelUpdate();
    bit rdy, vld, ill32, ill64;
    logic [63:0] d_imm;
    logic [2:0]  d_fmt;
    if (!reset_n) begin
      modelReset();
    end else begin
      rdy = m_init_done && (q_inst.size() < 2);
      vld = q_inst.size() > 0;
      if (flush) begin
        q_inst.delete();
        q_tag.delete();
      end else begin
        if (vld && out_ready) begin
          void'(q_inst.pop_front());
          void'(q_tag.pop_front());
        end
        if (in_valid && rdy) begin
          q_inst.push_back(in_inst);
          q_tag.push_back(in_tag);
          refDecode(in_inst, 32, d_imm, d_fmt, ill32);
          refDecode(in_inst, 64, d_imm, d_fmt, ill64);
          if (ill32 && m_cnt32 < 65535) m_cnt32++;
          if (ill64 && m_cnt64 < 65535) m_cnt64++;
          if (ill32 && m_cntc2 < 3) m_cntc2++;
        end
      end
      m_init_done = 1;
    end
  endtask

  task automatic checkAll();
    logic        rdy, vld;
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    bit          e_ill;
    rdy = m_init_done && (q_inst.size() < 2);
    vld = q_inst.size() > 0;
    checkOutput("in_ready32", o32_in_ready, rdy);
    checkOutput("in_ready64", o64_in_ready, rdy);
    checkOutput("in_readyc2", oc2_in_ready, rdy);
    checkOutput("out_valid32", o32_out_valid, vld);
    checkOutput("out_valid64", o64_out_valid, vld);
    checkOutput("out_validc2", oc2_out_valid, vld);
    checkOutput("cnt32", o32_cnt, m_cnt32);
    checkOutput("cnt64", o64_cnt, m_cnt64);
    checkOutput("cntc2", oc2_cnt, m_cntc2);
    if (vld) begin
      refDecode(q_inst[0], 32, e_imm, e_fmt, e_ill);
      checkOutput("imm32", o32_out_imm, e_imm);
      checkOutput("fmt32", o32_out_fmt, e_fmt);
      checkOutput("ill32", o32_out_illegal, e_ill);
      checkOutput("tag32", o32_out_tag, q_tag[0]);
      checkOutput("immc2", oc2_out_imm, e_imm);
      checkOutput("fmtc2", oc2_out_fmt, e_fmt);
      checkOutput("tagc2", oc2_out_tag, q_tag[0]);
      refDecode(q_inst[0], 64, e_imm, e_fmt, e_ill);
      checkOutput("imm64", o64_out_imm, e_imm);
      checkOutput("fmt64", o64_out_fmt, e_fmt);
      checkOutput("ill64", o64_out_illegal, e_ill);
      checkOutput("tag64", o64_out_tag, q_tag[0]);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_ready", {o32_in_ready, o64_in_ready, oc2_in_ready}, 0);
    checkOutput("rst_valid", {o32_out_valid, o64_out_valid, oc2_out_valid}, 0);
    checkOutput("rst_imm32", o32_out_imm, 0);
    checkOutput("rst_imm64", o64_out_imm, 0);
    checkOutput("rst_fmt", {o32_out_fmt, o64_out_fmt, oc2_out_fmt}, 0);
    checkOutput("rst_tag", {o32_out_tag, o64_out_tag, oc2_out_tag}, 0);
    checkOutput("rst_ill", {o32_out_illegal, o64_out_illegal, oc2_out_illegal}, 0);
    checkOutput("rst_cnt", {o32_cnt, o64_cnt, oc2_cnt}, 0);
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] inst, input logic [7:0] tag,
                               input bit ordy, input bit fl);
    in_valid  = v;
    in_inst   = inst;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkAll();
  endtask

  task automatic releaseReset();
    reset_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", {o32_in_ready, o64_in_ready, oc2_in_ready}, 0);
    @(negedge clk);
  endtask

  task automatic directed(input logic [31:0] inst, input logic [63:0] exp, input logic [2:0] fmt);
    applyStimulus(1, inst, inst[7:0], 0, 0);
    step();
    checkOutput("dir_imm32", o32_out_imm, {32'b0, exp[31:0]});
    checkOutput("dir_imm64", o64_out_imm, exp);
    checkOutput("dir_fmt32", o32_out_fmt, fmt);
    checkOutput("dir_fmt64", o64_out_fmt, fmt);
    applyStimulus(0, 0, 0, 1, 0);
    step();
  endtask

  function automatic logic [31:0] randInst();
    logic [6:0] ops [16];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h7F, 7'h13, 7'h1B};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 15)];
    return w;
  endfunction

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(negedge clk);
    checkReset();
    releaseReset();
    step();

    directed(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd0);
    directed(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd2);
    directed(32'h0010006F, 64'h0000000000000800, 3'd4);
    directed(32'h4030D093, 64'h0000000000000003, 3'd5);
    directed(32'h800000B7, 64'hFFFFFFFF80000000, 3'd3);

    applyStimulus(1, 32'h0000007F, 8'h7F, 0, 0);
    step();
    checkOutput("illegal_flag", o32_out_illegal, 1);
    checkOutput("illegal_fmt", o32_out_fmt, 7);
    checkOutput("illegal_imm", o32_out_imm, 0);
    checkOutput("illegal_cnt1", o32_cnt, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 32'h0000007F, 8'(k), 1, 0);
      step();
    end
    applyStimulus(0, 0, 0, 1, 0);
    repeat (2) step();
    checkOutput("sat_cntc2", oc2_cnt, 3);
    checkOutput("cnt32_six", o32_cnt, 6);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h00500113 + 32'(k << 20), 8'h11 * 8'(k + 1), 0, 0);
      step();
    end
    checkOutput("full_ready", o32_in_ready, 0);
    checkOutput("full_tag0", o32_out_tag, 8'h11);
    applyStimulus(0, 0, 0, 1, 0);
    step();
    checkOutput("drain_tag1", o32_out_tag, 8'h22);
    step();

    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 32'h00000023, 8'hA0 + 8'(k), 0, 0);
      step();
    end
    applyStimulus(1, 32'h0000007F, 8'hEE, 0, 1);
    step();
    checkOutput("flush_valid", o32_out_valid, 0);
    checkOutput("flush_cnt", o32_cnt, 6);
    applyStimulus(0, 0, 0, 0, 0);
    step();

    applyStimulus(1, 32'hFFF00093, 8'h5A, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    @(posedge clk);
    modelUpdate();
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkReset();
    @(negedge clk);
    releaseReset();
    step();

    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, randInst(), 8'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 8, width of sideband tag carried with each instruction.
REQ-003 SHALL have parameter CNT_W, default 16, width of the illegal-opcode counter.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-007 SHALL have port in_valid  input  1  instruction offered.
REQ-008 SHALL have port in_ready  output  1  stage can accept.
REQ-009 SHALL have port in_inst  input  32  instruction word.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband tag.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts.
REQ-013 SHALL have port out_imm  output  XLEN  decoded immediate.
REQ-014 SHALL have port out_fmt  output  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 7 NONE.
REQ-015 SHALL have port out_illegal  output  1  opcode not supported.
REQ-016 SHALL have port out_tag  output  TAG_W  tag of head entry.
REQ-017 SHALL have port illegal_cnt  output  CNT_W  count of illegal opcodes accepted.

Function
REQ-018 Decode on inst[6:0]: I for 0000011, 0010011, 1100111, 1110011, and 0011011 (XLEN=64 only); S 0100011; B 1100011; U 0110111, 0010111; J 1101111; NONE for 0110011, 0111011 (XLEN=64 only), 0001111; any other opcode is illegal.
REQ-019 I: sext(inst[31:20]); S: sext({inst[31:25],inst[11:7]}); B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); U: sext({inst[31:12],12'b0}); sign extension is to XLEN.
REQ-020 SHAMT replaces I when the opcode is 0010011 or 0011011 with funct3 001 or 101: imm = zero-extended inst[24:20] (XLEN=32 or opcode 0011011), else inst[25:20]; funct7 bits are excluded.
REQ-021 NONE and illegal entries carry imm = 0; illegal entries additionally carry fmt = 7 and out_illegal = 1.
REQ-022 Decode is registered into a 2-entry FIFO; an accepted instruction appears at the output no earlier than the next cycle (latency 1 when the FIFO is empty).
REQ-023 in_ready = (count < 2), registered-state-derived only, with no combinational path from out_ready.
REQ-024 Push on in_valid & in_ready; pop on out_valid & out_ready; simultaneous push and pop with count=1 keeps count=1 and preserves order.
REQ-025 out_valid = (count > 0); out_imm, out_fmt, out_illegal and out_tag SHALL hold stable while out_valid & !out_ready.
REQ-026 Read/write pointers are 1 bit and wrap modulo 2.
REQ-027 flush sets count=0 and resets pointers next edge, overriding same-cycle push and pop; an instruction offered during flush is dropped and not counted.
REQ-028 illegal_cnt increments by 1 per accepted illegal instruction, saturates at 2^CNT_W-1, and is unaffected by flush.

Reset
REQ-029 On reset_n low, immediately and independent of clk: count=0, pointers=0, out_valid=0, in_ready=0, illegal_cnt=0, and out_imm/out_fmt/out_tag/out_illegal = 0.
REQ-030 in_ready SHALL rise on the first clk edge after reset_n deasserts; reset asserted mid-transfer discards all entries.

Verification
REQ-031 XLEN=32, push 0xFFF00093 -> next cycle out_imm=0xFFFFFFFF, fmt=0; push 0xFE000EE3 -> imm=0xFFFFFFFC, fmt=2.
REQ-032 Push 0x0010006F -> imm=0x00000800, fmt=4; push 0x4030D093 -> imm=0x00000003, fmt=5.
REQ-033 XLEN=64, push 0x800000B7 -> imm=0xFFFFFFFF80000000, fmt=3.
REQ-034 Push 0x0000007F -> out_illegal=1, fmt=7, imm=0, illegal_cnt 0->1; CNT_W=2, five illegal pushes -> illegal_cnt stays 3.
REQ-035 out_ready=0, in_valid=1 for 4 cycles -> two entries accepted, in_ready=0 thereafter; out_ready=1 -> entries drain in order with matching tags.
REQ-036 With 2 entries held, assert flush with in_valid=1 -> next cycle out_valid=0, count=0, illegal_cnt unchanged; assert reset_n=0 mid-stream -> outputs cleared without a clk edge.
